// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Carries GPR and HI/LO write-back results; adds backpressure, NOP bubbles, flush and a bubble counter.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } entry_t;

  // Encoding mirrors (main_v, skid_v); (0,1) is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL1 = 2'b10,
    FULL2 = 2'b11
  } state_e;

  state_e           state_q;
  entry_t           main_q;
  entry_t           skid_q;
  entry_t           ex_entry;
  logic [CNT_W-1:0] bubble_q;
  logic             accept;
  logic             pop;

  assign ex_entry = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                      whilo: ex_whilo, hi: ex_hi, lo: ex_lo};

  // ex_ready depends only on registered state, never on mem_ready.
  assign ex_ready  = (state_q != FULL2);
  assign mem_valid = (state_q != EMPTY);
  assign accept    = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;

  // NOTE: payload registers are reset too, because the empty register must present a NOP (all zero) to MEM.
  // NOTE: every register here uses <= so all updates see the pre-edge values of state_q/main_q/skid_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      bubble_q <= '0;
    end else begin
      if (state_q == EMPTY && bubble_q != {CNT_W{1'b1}}) begin
        bubble_q <= bubble_q + 1'b1;
      end

      if (flush) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_q <= FULL1;
              main_q  <= ex_entry;
            end
          end
          FULL1: begin
            if (pop && accept) begin
              main_q <= ex_entry;
            end else if (pop) begin
              state_q <= EMPTY;
              main_q  <= '0;
            end else if (accept) begin
              state_q <= FULL2;
              skid_q  <= ex_entry;
            end
          end
          FULL2: begin
            if (pop) begin
              state_q <= FULL1;
              main_q  <= skid_q;
              skid_q  <= '0;
            end
          end
          default: begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
          end
        endcase
      end
    end
  end

  assign mem_wd     = main_q.wd;
  assign mem_wreg   = main_q.wreg & mem_valid;
  assign mem_wdata  = main_q.wdata;
  assign mem_whilo  = main_q.whilo & mem_valid;
  assign mem_hi     = main_q.hi;
  assign mem_lo     = main_q.lo;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed self-checking bench for ex_mem_skid (CNT_W=4 so counter saturation is reachable quickly).
module tb_ex_mem_skid;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic [ADDR_W-1:0] ex_wd;
  logic              ex_wreg;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_whilo;
  logic [DATA_W-1:0] ex_hi;
  logic [DATA_W-1:0] ex_lo;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_whilo;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;
  logic [CNT_W-1:0]  bubble_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  ex_mem_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] wd, input logic wreg,
                       input logic [DATA_W-1:0] wdata, input logic whilo,
                       input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo);
    ex_valid = v;
    ex_wd    = wd;
    ex_wreg  = wreg;
    ex_wdata = wdata;
    ex_whilo = whilo;
    ex_hi    = hi;
    ex_lo    = lo;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    #1;
    check("rst_mem_valid", mem_valid, 0);
    check("rst_ex_ready", ex_ready, 1);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_mem_wd", mem_wd, 0);
    #1 rst = 1'b0;

    // 1: single entry, one-cycle latency
    mem_ready = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 32'h1234, 1'b0, '0, '0);
    step();
    check("t1_valid", mem_valid, 1);
    check("t1_wd", mem_wd, 5);
    check("t1_wdata", mem_wdata, 32'h1234);
    check("t1_wreg", mem_wreg, 1);
    check("t1_bubble", bubble_cnt, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    step();
    check("t1_empty_valid", mem_valid, 0);
    check("t1_empty_wd", mem_wd, 0);
    check("t1_empty_wdata", mem_wdata, 0);
    check("t1_empty_wreg", mem_wreg, 0);

    // 2: A, B, C under backpressure then drain
    mem_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 32'hA, 1'b0, '0, '0);
    step();
    check("t2_a_main", mem_wdata, 32'hA);
    check("t2_a_ready", ex_ready, 1);
    drive(1'b1, 5'd2, 1'b1, 32'hB, 1'b0, '0, '0);
    step();
    check("t2_b_skid_ready", ex_ready, 0);
    check("t2_b_main", mem_wdata, 32'hA);
    drive(1'b1, 5'd3, 1'b1, 32'hC, 1'b0, '0, '0);
    step();
    check("t2_c_held_ready", ex_ready, 0);
    check("t2_c_held_main", mem_wdata, 32'hA);
    mem_ready = 1'b1;
    step();
    check("t2_see_b", mem_wdata, 32'hB);
    check("t2_see_b_wd", mem_wd, 2);
    check("t2_ready_back", ex_ready, 1);
    step();
    check("t2_see_c", mem_wdata, 32'hC);
    check("t2_see_c_valid", mem_valid, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    step();
    check("t2_drained", mem_valid, 0);

    // 3: FULL1 with simultaneous pop and accept
    mem_ready = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'h7777, 1'b0, '0, '0);
    step();
    mem_ready = 1'b1;
    drive(1'b1, 5'd8, 1'b1, 32'hD, 1'b0, '0, '0);
    step();
    check("t3_main_d", mem_wdata, 32'hD);
    check("t3_wd_d", mem_wd, 8);
    check("t3_ready", ex_ready, 1);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    step();
    check("t3_skid_empty", mem_valid, 0);

    // 4: flush from FULL2 drops the simultaneous accept
    mem_ready = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'hE, 1'b1, 32'h1, 32'h2);
    step();
    drive(1'b1, 5'd10, 1'b1, 32'hF, 1'b0, '0, '0);
    step();
    check("t4_full2_ready", ex_ready, 0);
    flush = 1'b1; mem_ready = 1'b1;
    drive(1'b1, 5'd11, 1'b1, 32'h6, 1'b1, 32'h3, 32'h4);
    step();
    check("t4_flush_valid", mem_valid, 0);
    check("t4_flush_wreg", mem_wreg, 0);
    check("t4_flush_whilo", mem_whilo, 0);
    check("t4_flush_ready", ex_ready, 1);
    check("t4_flush_wdata", mem_wdata, 0);
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    step();
    check("t4_dropped", mem_valid, 0);
    check("t4_bubble", bubble_cnt, 5);

    // 5: HI/LO write-back only
    drive(1'b1, 5'd3, 1'b0, 32'h77, 1'b1, 32'hDEAD, 32'hBEEF);
    step();
    check("t5_whilo", mem_whilo, 1);
    check("t5_hi", mem_hi, 32'hDEAD);
    check("t5_lo", mem_lo, 32'hBEEF);
    check("t5_wreg", mem_wreg, 0);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    step();
    check("t5_clear_whilo", mem_whilo, 0);
    check("t5_clear_hi", mem_hi, 0);
    check("t5_clear_lo", mem_lo, 0);

    // 6: counter saturation, then asynchronous reset mid-cycle
    for (int i = 0; i < 20; i++) step();
    check("t6_saturate", bubble_cnt, 15);
    mem_ready = 1'b0;
    drive(1'b1, 5'd31, 1'b1, 32'hCAFE, 1'b1, 32'h5, 32'h6);
    step();
    check("t6_loaded", mem_valid, 1);
    check("t6_sat_hold", bubble_cnt, 15);
    #2 rst = 1'b1;
    #1;
    check("t6_arst_valid", mem_valid, 0);
    check("t6_arst_wd", mem_wd, 0);
    check("t6_arst_wdata", mem_wdata, 0);
    check("t6_arst_wreg", mem_wreg, 0);
    check("t6_arst_whilo", mem_whilo, 0);
    check("t6_arst_hi", mem_hi, 0);
    check("t6_arst_bubble", bubble_cnt, 0);
    check("t6_arst_ready", ex_ready, 1);
    #1 rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
